// File: rtl/oram_req_arbiter.sv
// oram_req_arbiter: round-robin sharing of one ORAM front-end port between NumReq requesters.
// Define ORAM_ARB_GRANT_COUNT_EN to add the per-requester GrantCount output.
module oram_req_arbiter #(
  parameter int NumReq      = 2,
  parameter int ReqIdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1,
  parameter int BECMDWidth  = 2,
  parameter int ORAMU       = 32,
  parameter int FEDWidth    = 64,
  parameter int ORAMB       = 512,
  parameter int TagDepth    = 8
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [NumReq*BECMDWidth-1:0] ReqCommand,
  input  logic [NumReq*ORAMU-1:0]      ReqPAddr,
  input  logic [NumReq-1:0]            ReqCommandValid,
  output logic [NumReq-1:0]            ReqCommandReady,
  input  logic [NumReq*FEDWidth-1:0]   ReqDataIn,
  input  logic [NumReq-1:0]            ReqDataInValid,
  output logic [NumReq-1:0]            ReqDataInReady,
  output logic [FEDWidth-1:0]          ReqDataOut,
  output logic [NumReq-1:0]            ReqDataOutValid,
  input  logic [NumReq-1:0]            ReqDataOutReady,
  output logic [BECMDWidth-1:0]        ORAMCommand,
  output logic [ORAMU-1:0]             ORAMPAddr,
  output logic                         ORAMCommandValid,
  input  logic                         ORAMCommandReady,
  output logic [FEDWidth-1:0]          ORAMDataIn,
  output logic                         ORAMDataInValid,
  input  logic                         ORAMDataInReady,
  input  logic [FEDWidth-1:0]          ORAMDataOut,
`ifdef ORAM_ARB_GRANT_COUNT_EN
  output logic [NumReq*16-1:0]         GrantCount,
`endif
  input  logic                         ORAMDataOutValid,
  output logic                         ORAMDataOutReady
);

  localparam int Beats   = ORAMB / FEDWidth;
  localparam int BeatW   = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int TagPtrW = (TagDepth > 1) ? $clog2(TagDepth) : 1;
  localparam int TagCntW = $clog2(TagDepth + 1);

  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
  localparam logic [TagPtrW-1:0] LastTag = TagPtrW'(TagDepth - 1);
  localparam logic [TagCntW-1:0] TagFull = TagCntW'(TagDepth);
  localparam logic [ReqIdxWidth-1:0] LastReq = ReqIdxWidth'(NumReq - 1);

  localparam logic [BECMDWidth-1:0] BECMD_Update = BECMDWidth'(0);
  localparam logic [BECMDWidth-1:0] BECMD_Append = BECMDWidth'(1);

  typedef enum logic [1:0] {
    ST_Idle,
    ST_Cmd,
    ST_WrData
  } state_t;

  state_t state, nextState;

  logic [ReqIdxWidth-1:0] grant;
  logic [ReqIdxWidth-1:0] ptr;
  logic [ReqIdxWidth-1:0] pick;
  logic [ReqIdxWidth-1:0] scan;
  logic [ReqIdxWidth-1:0] grantNext;
  logic                   found;

  logic [BECMDWidth-1:0] cmdArr [NumReq];
  logic [ORAMU-1:0]      addrArr [NumReq];
  logic [FEDWidth-1:0]   dinArr [NumReq];

  logic [BECMDWidth-1:0] grantCmd;
  logic grantIsWrite;
  logic grantValid;
  logic cmdBlocked;
  logic cmdFire;
  logic wrFire;
  logic lastWrBeat;
  logic rdFire;
  logic lastRdBeat;
  logic tagPush;
  logic tagPop;
  logic tagEmpty;

  logic [BeatW-1:0] wrBeat;
  logic [BeatW-1:0] rdBeat;

  logic [ReqIdxWidth-1:0] tagMem [TagDepth];
  logic [TagPtrW-1:0]     tagWr;
  logic [TagPtrW-1:0]     tagRd;
  logic [TagCntW-1:0]     tagCnt;
  logic [ReqIdxWidth-1:0] head;

  for (genvar r = 0; r < NumReq; r++) begin : g_unpack
    assign cmdArr[r]  = ReqCommand[r*BECMDWidth +: BECMDWidth];
    assign addrArr[r] = ReqPAddr[r*ORAMU +: ORAMU];
    assign dinArr[r]  = ReqDataIn[r*FEDWidth +: FEDWidth];
  end

  assign grantCmd     = cmdArr[grant];
  assign grantValid   = ReqCommandValid[grant];
  assign grantIsWrite = (grantCmd == BECMD_Update) ||
                        (grantCmd == BECMD_Append);
  assign grantNext    = (grant == LastReq) ? '0 : grant + 1'b1;

  assign ORAMCommand = grantCmd;
  assign ORAMPAddr   = addrArr[grant];
  assign ORAMDataIn  = dinArr[grant];

  // Reads stall in ST_Cmd while every tag slot is taken.
  assign cmdBlocked = ~grantIsWrite & (tagCnt == TagFull);
  assign cmdFire    = ORAMCommandValid & ORAMCommandReady;
  assign wrFire     = ORAMDataInValid & ORAMDataInReady;
  assign lastWrBeat = (wrBeat == LastBeat);
  assign tagPush    = cmdFire & ~grantIsWrite;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = ptr;
    for (int i = 0; i < NumReq; i++) begin
      if (!found && ReqCommandValid[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
      scan = (scan == LastReq) ? '0 : scan + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_Idle;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      ST_Idle: begin
        if (found) nextState = ST_Cmd;
      end
      ST_Cmd: begin
        if (!grantValid) begin
          nextState = ST_Idle;
        end else if (cmdFire) begin
          nextState = grantIsWrite ? ST_WrData : ST_Idle;
        end
      end
      ST_WrData: begin
        if (wrFire && lastWrBeat) nextState = ST_Idle;
      end
      default: nextState = ST_Idle;
    endcase
  end

  always_comb begin
    ORAMCommandValid = 1'b0;
    ReqCommandReady  = '0;
    ORAMDataInValid  = 1'b0;
    ReqDataInReady   = '0;
    unique case (state)
      ST_Cmd: begin
        ORAMCommandValid       = grantValid & ~cmdBlocked;
        ReqCommandReady[grant] = ORAMCommandReady & ~cmdBlocked;
      end
      ST_WrData: begin
        ORAMDataInValid       = ReqDataInValid[grant];
        ReqDataInReady[grant] = ORAMDataInReady;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      grant  <= '0;
      ptr    <= '0;
      wrBeat <= '0;
      rdBeat <= '0;
    end else begin
      if (state == ST_Idle && found) grant <= pick;
      if (cmdFire && grantIsWrite) wrBeat <= '0;
      if (wrFire) wrBeat <= lastWrBeat ? '0 : wrBeat + 1'b1;
      if (tagPush || (wrFire && lastWrBeat)) ptr <= grantNext;
      if (rdFire) rdBeat <= lastRdBeat ? '0 : rdBeat + 1'b1;
    end
  end

  // Return path: the FIFO head names the requester owning the current read burst.
  assign head       = tagMem[tagRd];
  assign tagEmpty   = (tagCnt == '0);
  assign ReqDataOut = ORAMDataOut;

  always_comb begin
    ReqDataOutValid       = '0;
    ReqDataOutValid[head] = ORAMDataOutValid & ~tagEmpty;
  end

  assign ORAMDataOutReady = ReqDataOutReady[head] & ~tagEmpty;
  assign rdFire           = ORAMDataOutValid & ORAMDataOutReady;
  assign lastRdBeat       = (rdBeat == LastBeat);
  assign tagPop           = rdFire & lastRdBeat;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tagWr  <= '0;
      tagRd  <= '0;
      tagCnt <= '0;
      for (int i = 0; i < TagDepth; i++) tagMem[i] <= '0;
    end else begin
      if (tagPush) begin
        tagMem[tagWr] <= grant;
        tagWr <= (tagWr == LastTag) ? '0 : tagWr + 1'b1;
      end
      if (tagPop) begin
        tagRd <= (tagRd == LastTag) ? '0 : tagRd + 1'b1;
      end
      tagCnt <= tagCnt + TagCntW'(tagPush) - TagCntW'(tagPop);
    end
  end

`ifdef ORAM_ARB_GRANT_COUNT_EN
  for (genvar r = 0; r < NumReq; r++) begin : g_cnt
    logic [15:0] cnt;
    always_ff @(posedge Clock) begin
      if (Reset) begin
        cnt <= '0;
      end else if (cmdFire && grant == ReqIdxWidth'(r) &&
                   cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign GrantCount[r*16 +: 16] = cnt;
  end
`endif

endmodule
